// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared types and constants for the seven-segment scan sequencer.
//   state_t    - scan FSM states (GUARD: all anodes off, DRIVE: one digit lit)
//   disp_t     - one complete display image (digits, blank, blink, colon)
//   SEG_*      - active-low segment patterns, bit order {g,f,e,d,c,b,a}
package seg_scan_pkg;

  typedef enum logic {
    GUARD = 1'b0,
    DRIVE = 1'b1
  } state_t;

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'h3F;

  localparam logic [6:0] GLYPH_0 = 7'h40;
  localparam logic [6:0] GLYPH_1 = 7'h79;
  localparam logic [6:0] GLYPH_2 = 7'h24;
  localparam logic [6:0] GLYPH_3 = 7'h30;
  localparam logic [6:0] GLYPH_4 = 7'h19;
  localparam logic [6:0] GLYPH_5 = 7'h12;
  localparam logic [6:0] GLYPH_6 = 7'h02;
  localparam logic [6:0] GLYPH_7 = 7'h78;
  localparam logic [6:0] GLYPH_8 = 7'h00;
  localparam logic [6:0] GLYPH_9 = 7'h10;

  typedef struct packed {
    logic [15:0] digits;  // [3:0] is digit 0 (rightmost)
    logic [3:0]  blank;
    logic [3:0]  blink;
    logic        colon;
  } disp_t;

  // Dark until the first update arrives.
  localparam disp_t DISP_RESET = '{digits: 16'h0000, blank: 4'hF, blink: 4'h0, colon: 1'b0};

endpackage

// File: rtl/seg_scan_ctrl_bcd_to_seg.sv
// bcd_to_seg: combinational nibble to active-low seven-segment decoder.
//   nibble in  4  value to show (0-9 glyphs, 4'hA dash, 4'hB-4'hF dark)
//   seg    out 7  {g,f,e,d,c,b,a}, active-low
module bcd_to_seg
  import seg_scan_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (nibble)
      4'd0:    seg = GLYPH_0;
      4'd1:    seg = GLYPH_1;
      4'd2:    seg = GLYPH_2;
      4'd3:    seg = GLYPH_3;
      4'd4:    seg = GLYPH_4;
      4'd5:    seg = GLYPH_5;
      4'd6:    seg = GLYPH_6;
      4'd7:    seg = GLYPH_7;
      4'd8:    seg = GLYPH_8;
      4'd9:    seg = GLYPH_9;
      4'hA:    seg = SEG_DASH;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 4-digit multiplexed seven-segment scan sequencer.
// Each digit slot is GUARD_CYCLES with all anodes off followed by
// DRIVE_CYCLES with one anode low. Updates enter a one-entry staging buffer
// and are copied to the displayed shadow image only at the frame boundary
// (the edge that ends DRIVE of digit 3), so a frame never mixes two images.
//
// Handshake: upd_ready is high while the staging buffer is empty; an update
// transfers on any rising edge where upd_valid && upd_ready. The producer may
// hold upd_valid and the fields steady until that edge.
//
// Ports:
//   clk, reset (async, active-low)
//   upd_valid/upd_ready, upd_digits[15:0], upd_blank[3:0], upd_blink[3:0],
//   upd_colon                         - update channel
//   selector[1:0], an[3:0], seg[6:0], dp - display drive (an/seg/dp active-low)
//   frame_start                       - one-cycle pulse after each boundary
//
// Build option: define SEG_SCAN_BLINK_EN to build the blink frame counter;
// otherwise blink_phase is constant 0 and upd_blink has no visible effect.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int DRIVE_CYCLES = 50000,
  parameter int GUARD_CYCLES = 500,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [15:0] upd_digits,
  input  logic [3:0]  upd_blank,
  input  logic [3:0]  upd_blink,
  input  logic        upd_colon,
  output logic [1:0]  selector,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_start
);

  localparam int MAX_CYC = (DRIVE_CYCLES > GUARD_CYCLES) ? DRIVE_CYCLES : GUARD_CYCLES;
  localparam int CW = $clog2(MAX_CYC) + 1;
  localparam logic [CW-1:0] DRIVE_LAST = CW'(DRIVE_CYCLES - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYCLES - 1);

  state_t        state, state_next;
  logic [CW-1:0] cnt;
  logic          guard_end, slot_end, boundary;

  logic          pending;
  disp_t         staging, shadow;
  logic          blink_phase;

  logic [3:0]    cur_nibble;
  logic [6:0]    cur_glyph;
  logic          cur_dark;
  logic [3:0]    an_next;
  logic [6:0]    seg_next;
  logic          dp_next;

  assign upd_ready = ~pending;

  // Shadow only changes on the boundary edge, i.e. during GUARD, so the
  // values sampled at the GUARD->DRIVE edge hold for the whole DRIVE slot.
  assign cur_nibble = shadow.digits[{selector, 2'b00} +: 4];
  assign cur_dark   = shadow.blank[selector] | (shadow.blink[selector] & blink_phase);

  bcd_to_seg u_dec (
    .nibble (cur_nibble),
    .seg    (cur_glyph)
  );

  // Next-state and next-output logic. an/seg/dp are loaded only on the two
  // slot transition edges so anode and segments always switch together.
  always_comb begin
    state_next = state;
    guard_end  = 1'b0;
    slot_end   = 1'b0;
    an_next    = an;
    seg_next   = seg;
    dp_next    = dp;
    case (state)
      GUARD: begin
        if (cnt == GUARD_LAST) begin
          guard_end  = 1'b1;
          state_next = DRIVE;
          an_next    = ~(4'b0001 << selector);
          seg_next   = cur_dark ? SEG_OFF : cur_glyph;
          dp_next    = ~((selector == 2'd1) & shadow.colon & ~cur_dark);
        end
      end
      DRIVE: begin
        if (cnt == DRIVE_LAST) begin
          slot_end   = 1'b1;
          state_next = GUARD;
          an_next    = 4'hF;
          seg_next   = SEG_OFF;
          dp_next    = 1'b1;
        end
      end
      default: state_next = GUARD;
    endcase
    boundary = slot_end & (selector == 2'd3);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= GUARD;
      cnt         <= '0;
      selector    <= 2'd0;
      an          <= 4'hF;
      seg         <= SEG_OFF;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= (guard_end | slot_end) ? '0 : cnt + CW'(1);
      if (slot_end) selector <= selector + 2'd1;
      an          <= an_next;
      seg         <= seg_next;
      dp          <= dp_next;
      frame_start <= boundary;
    end
  end

  // Staging buffer and shadow image. An offer on the boundary edge is only
  // accepted when nothing was pending, and then waits for the next boundary.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= 1'b0;
      staging <= DISP_RESET;
      shadow  <= DISP_RESET;
    end else if (boundary && pending) begin
      shadow  <= staging;
      pending <= 1'b0;
    end else if (upd_valid && !pending) begin
      staging <= '{digits: upd_digits, blank: upd_blank, blink: upd_blink, colon: upd_colon};
      pending <= 1'b1;
    end
  end

`ifdef SEG_SCAN_BLINK_EN
  localparam int FW = $clog2(BLINK_FRAMES) + 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  logic [FW-1:0] frame_cnt;

  // The phase flips on the boundary that completes BLINK_FRAMES frames.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (boundary) begin
      if (frame_cnt == FRAME_LAST) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + FW'(1);
      end
    end
  end
`else
  // BLINK_FRAMES is at least 1, so this is constant 0; it keeps the
  // parameter referenced in the build without blink support.
  assign blink_phase = (BLINK_FRAMES < 1);
`endif

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: randomized scoreboard bench for seg_scan_ctrl.
// A timeline model works from the cycle index since reset release: the
// position inside a 24-cycle frame gives digit and GUARD/DRIVE directly, and
// the blink phase is derived from the number of frames completed.
module tb_seg_scan_ctrl;

  localparam int D = 4;
  localparam int G = 2;
  localparam int B = 2;
  localparam int SLOT = G + D;
  localparam int FRAME = 4 * SLOT;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        upd_valid = 1'b0;
  logic        upd_ready;
  logic [15:0] upd_digits = '0;
  logic [3:0]  upd_blank = '0;
  logic [3:0]  upd_blink = '0;
  logic        upd_colon = 1'b0;
  logic [1:0]  selector;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;

  always #5 clk = ~clk;

  seg_scan_ctrl #(
    .DRIVE_CYCLES (D),
    .GUARD_CYCLES (G),
    .BLINK_FRAMES (B)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .upd_valid   (upd_valid),
    .upd_ready   (upd_ready),
    .upd_digits  (upd_digits),
    .upd_blank   (upd_blank),
    .upd_blink   (upd_blink),
    .upd_colon   (upd_colon),
    .selector    (selector),
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .frame_start (frame_start)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];   // {selector, an, seg, dp, frame_start, upd_ready}

  // Reference model state
  int          t;          // index of the current cycle since reset release
  int          frames;     // frame boundaries passed since reset
  bit          m_pending;
  logic [15:0] st_d, sh_d;
  logic [3:0]  st_bl, sh_bl, st_bk, sh_bk;
  bit          st_c, sh_c;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      4'hA: return 7'h3F;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [15:0] expect_now();
    int p, slot, q;
    bit phase, dark, dpv, fs;
    logic [3:0] anv, nib;
    logic [6:0] sg;
    p = t % FRAME;
    slot = p / SLOT;
    q = p % SLOT;
`ifdef SEG_SCAN_BLINK_EN
    phase = ((frames / B) % 2) == 1;
`else
    phase = 1'b0;
`endif
    anv = 4'hF;
    sg  = 7'h7F;
    dpv = 1'b1;
    if (q >= G) begin
      anv[slot] = 1'b0;
      nib  = sh_d[slot*4 +: 4];
      dark = sh_bl[slot] | (sh_bk[slot] & phase);
      sg   = dark ? 7'h7F : glyph(nib);
      dpv  = !(slot == 1 && sh_c && !dark);
    end
    fs = (t > 0) && (p == 0);
    return {2'(slot), anv, sg, dpv, fs, !m_pending};
  endfunction

  task automatic model_reset();
    t = 0; frames = 0; m_pending = 0;
    st_d = '0; st_bl = 4'hF; st_bk = '0; st_c = 0;
    sh_d = '0; sh_bl = 4'hF; sh_bk = '0; sh_c = 0;
  endtask

  // Model: advance one clock edge and queue the expectation for the next cycle.
  always @(posedge clk) begin
    bit bnd, acc;
    if (!reset) begin
      model_reset();
    end else begin
      bnd = (t % FRAME) == FRAME - 1;
      acc = upd_valid && !m_pending;
      if (bnd && m_pending) begin
        sh_d = st_d; sh_bl = st_bl; sh_bk = st_bk; sh_c = st_c;
        m_pending = 0;
      end else if (acc) begin
        st_d = upd_digits; st_bl = upd_blank; st_bk = upd_blink; st_c = upd_colon;
        m_pending = 1;
      end
      if (bnd) frames++;
      t++;
    end
    exp_q.push_back(expect_now());
  end

  // Monitor: compare DUT outputs against the queued expectation each cycle.
  always @(negedge clk) begin
    logic [15:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {selector, an, seg, dp, frame_start, upd_ready};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs t=%0d act{sel,an,seg,dp,fs,rdy}=%h exp=%h", t, a, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a negedge; holds upd_valid until the DUT takes it.
  task automatic offer(input logic [15:0] d, input logic [3:0] bl, input logic [3:0] bk,
                       input logic c);
    bit ok;
    ok = 0;
    upd_digits = d; upd_blank = bl; upd_blink = bk; upd_colon = c;
    upd_valid = 1'b1;
    for (int i = 0; i < 3 * FRAME; i++) begin
      if (upd_ready) begin
        ok = 1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    upd_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL handshake act=timeout exp=accepted within %0d cycles", 3 * FRAME);
    end
  endtask

  task automatic wait_pos(input int p);
    bit found;
    found = 0;
    for (int i = 0; i <= FRAME; i++) begin
      if (t % FRAME == p) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL frame_pos act=not reached exp=%0d", p);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] rd;
    logic [3:0]  rbl;
    reset = 1'b0;
    idle(3);
    reset = 1'b1;

    // Idle after reset: shadow is dark, scan keeps running.
    idle(3 * FRAME);

    // First real image with colon.
    offer(16'h1234, 4'h0, 4'h0, 1'b1);
    idle(2 * FRAME);

    // Mid-frame update followed by a second offer held high.
    wait_pos(8);
    offer(16'h0A98, 4'h0, 4'h0, 1'b0);
    offer(16'h4567, 4'h2, 4'h0, 1'b1);
    idle(2 * FRAME);

    // Offer landing on the boundary edge itself.
    wait_pos(FRAME - 1);
    offer(16'h3210, 4'h0, 4'h0, 1'b1);
    idle(2 * FRAME);

    // Blink on digit 0.
    offer(16'h5678, 4'h0, 4'b0001, 1'b0);
    idle(7 * FRAME);

    // Random updates with random spacing.
    repeat (20) begin
      idle($urandom_range(0, 30));
      rd = 16'($urandom_range(0, 65535));
      rd[7:4] = 4'($urandom_range(0, 10));
      rbl = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      offer(rd, rbl, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end
    idle(2 * FRAME);

    // Asynchronous reset during DRIVE of digit 2, with an update pending.
    wait_pos(10);
    offer(16'h9999, 4'h0, 4'h0, 1'b1);
    wait_pos(2 * SLOT + G);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1}) begin
      errors++;
      $display("FAIL async_reset act{an,seg,dp}=%h exp=%h", {an, seg, dp}, {4'hF, 7'h7F, 1'b1});
    end
    checks++;
    if ({selector, upd_ready, frame_start} !== {2'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL async_reset_ctl act{sel,rdy,fs}=%b exp=%b",
               {selector, upd_ready, frame_start}, {2'd0, 1'b1, 1'b0});
    end
    idle(3);
    reset = 1'b1;
    idle(2 * FRAME);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Sequencer for the alarm clock's 4-digit multiplexed seven-segment display. It owns the 2-bit digit selector, the active-low anode and segment drives, and a guard interval between digits. Time and alarm values arrive through a one-entry valid/ready staging buffer and are applied only at frame boundaries, so the display never tears. It sits between the time/alarm logic and the board display pins.

## Interface
- DRIVE_CYCLES, 50000, clocks each digit is lit (>=1)
- GUARD_CYCLES, 500, clocks all anodes are off before each digit (>=1)
- BLINK_FRAMES, 64, frames per blink half-period (>=1)
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- upd_valid  in  1  update offered
- upd_ready  out  1  staging buffer empty
- upd_digits  in  16  four BCD nibbles; [3:0] is digit 0 (rightmost)
- upd_blank  in  4  per-digit force-off
- upd_blink  in  4  per-digit blink enable
- upd_colon  in  1  colon (dp of digit 1) on
- selector  out  2  current digit index
- an  out  4  anodes, active-low, one-hot-low during DRIVE
- seg  out  7  {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low
- frame_start  out  1  one-cycle pulse at each frame boundary

## Operation
- Two-state FSM: GUARD (an=4'b1111, seg=7'h7F, dp=1) for GUARD_CYCLES, then DRIVE for DRIVE_CYCLES. DRIVE->GUARD increments selector mod 4 (3->0 wraps).
- In DRIVE: an[selector]=0 and all other bits 1. seg is the decode of the shadow nibble selected by selector. A digit is forced dark (seg=7'h7F, dp=1) when its blank bit is set, or when its blink bit is set and blink_phase=1.
- Decode: 0-9 standard glyphs; 4'hA is '-' (seg=7'h3F); 4'hB-4'hF are dark.
- dp=0 only when selector==1, colon is set in shadow, and the digit is not dark.
- Handshake: upd_ready = !pending. An update is accepted on an edge where upd_valid && upd_ready: fields are copied into staging and pending is set to 1.
- Frame boundary: the edge on which DRIVE of digit 3 ends. On that edge, if pending was 1 before the edge, staging is copied to shadow and pending is cleared.
  - An update accepted on the boundary edge itself (pending was 0) waits for the next boundary.
- Blink: a frame counter counts frame boundaries. blink_phase toggles on the boundary where the count reaches BLINK_FRAMES, and the counter then restarts at 0.
- Reset values:
  - state=GUARD, slot counter=0, selector=0, an=4'b1111, seg=7'h7F, dp=1, frame_start=0, upd_ready=1.
  - pending=0, blink_phase=0, frame counter=0.
  - shadow: digits=0, blank=4'b1111 (dark until the first update), blink=0, colon=0.
- A reset assertion mid-DRIVE blanks all outputs immediately (asynchronous). The staging contents are discarded.

## Timing
- All outputs are registered. an, seg and dp change together on the state-transition edge, so there is no glitch between anode and segment changes.
- Digit slot = GUARD_CYCLES + DRIVE_CYCLES clocks. Frame = 4 × slot.
- frame_start is high for the single cycle after the boundary edge, coincident with the first GUARD cycle of digit 0 and the first cycle the new shadow is visible.
- Update latency: from acceptance to visibility, at most one frame + 1 cycle and at least 1 cycle.
- After reset release, the first DRIVE of digit 0 begins GUARD_CYCLES clocks later.

## Configuration
- SEG_SCAN_BLINK_EN defined: blink logic as specified.
- SEG_SCAN_BLINK_EN undefined: the frame counter and blink_phase are not built, and blink_phase is tied to 0. upd_blink is still accepted and stored in staging but has no visible effect. Ports are unchanged.

## Structure
- Shared package seg_scan_pkg holds:
  - the state enum (GUARD, DRIVE)
  - SEG_OFF=7'h7F and SEG_DASH=7'h3F
  - the glyph constants for 0-9
- One sub-module, bcd_to_seg: combinational decoder from a 4-bit nibble to 7-bit active-low segments, instantiated once on the selected shadow nibble.

## Test plan
All scenarios use DRIVE_CYCLES=4, GUARD_CYCLES=2 and BLINK_FRAMES=2.
- Reset, then no update for 3 frames -> an stays 4'b1111 throughout. selector cycles 0,1,2,3 every 6 clocks. frame_start pulses every 24 clocks.
- Update digits=16'h1234, blank=0 -> after the next frame_start, digit 0 in DRIVE shows seg=7'h19 ('4') with an=4'b1110. Digit 3 shows seg=7'h79 ('1') with an=4'b0111.
- Update accepted mid-frame, then a second upd_valid held high -> upd_ready stays 0 until the boundary. The second update is accepted on the first cycle after the boundary and shown one frame later.
- Update accepted on the exact boundary edge -> not visible until the following frame_start.
- blink=4'b0001 with SEG_SCAN_BLINK_EN defined -> digit 0 is lit for 2 frames and dark for 2 frames, repeating. Without the macro -> digit 0 is always lit.
- Assert reset during DRIVE of digit 2 -> an=4'b1111 and seg=7'h7F in the same cycle, with no clock edge. After release, selector=0, upd_ready=1, and the shadow is dark.
